// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S sample sequencer slice.
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } seq_state_t;

  localparam int I2S_DATA_WIDTH = 16;

endpackage

// File: rtl/i2s_sync_fifo.sv
// Single-clock sample FIFO with a synchronous flush and an explicit occupancy counter.
module i2s_sync_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int LW         = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [LW-1:0]         level
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  // Storage carries no reset; discarding contents only needs the pointers cleared.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/i2s_sample_sequencer.sv
// Buffers producer samples and releases one per I2S frame, aligned to the LRCLK rise.
import i2s_pkg::*;

module i2s_sample_sequencer #(
  parameter int DATA_WIDTH  = I2S_DATA_WIDTH,
  parameter int FIFO_DEPTH  = 8,
  parameter int PRIME_LEVEL = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           enable,
  input  logic                           clr_stats,
  input  logic [DATA_WIDTH-1:0]          s_data,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic                           lrclk_in,
  output logic [DATA_WIDTH-1:0]          left_data,
  output logic                           data_valid,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
  output logic                           underrun,
  output logic [CNT_WIDTH-1:0]           underrun_cnt,
  output logic [1:0]                     state_o
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  seq_state_t            state;
  seq_state_t            state_nx;
  logic                  lr_s1;
  logic                  lr_s2;
  logic                  lr_s3;
  logic                  frame_stb;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_flush;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rd;
  logic [LW-1:0]         level;
  logic                  primed;
  logic                  underrun_evt;
  logic                  clear_out;

  // lrclk_in comes from the BCLK domain: two flops to synchronise, a third for the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lr_s1 <= 1'b0;
      lr_s2 <= 1'b0;
      lr_s3 <= 1'b0;
    end else begin
      lr_s1 <= lrclk_in;
      lr_s2 <= lr_s1;
      lr_s3 <= lr_s2;
    end
  end

  assign frame_stb = lr_s2 & ~lr_s3;
  assign primed    = (level >= LW'(PRIME_LEVEL));

  // Handshake: a sample transfers on a clock edge where s_valid & s_ready are both high;
  // s_ready depends only on enable and registered state, never on s_valid.
  assign s_ready   = enable & (state != IDLE) & ~fifo_full;
  assign fifo_push = s_valid & s_ready;

  i2s_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH),
    .LW         (LW)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (fifo_flush),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data (s_data),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (!enable) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    state_nx = PRIME;
        PRIME:   if (frame_stb && primed) state_nx = RUN;
        RUN:     if (frame_stb && fifo_empty) state_nx = PRIME;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Level is judged before this cycle's push, so a fresh sample is never released at once.
  always_comb begin
    fifo_pop     = 1'b0;
    fifo_flush   = 1'b0;
    underrun_evt = 1'b0;
    clear_out    = 1'b0;
    if (!enable || state == IDLE) begin
      fifo_flush = 1'b1;
      clear_out  = 1'b1;
    end else if (frame_stb) begin
      if (state == PRIME && primed) begin
        fifo_pop = 1'b1;
      end else if (state == RUN) begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
        end else begin
          underrun_evt = 1'b1;
          clear_out    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      left_data  <= '0;
      data_valid <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      underrun <= underrun_evt;
      if (clear_out) begin
        left_data  <= '0;
        data_valid <= 1'b0;
      end else if (fifo_pop) begin
        left_data  <= fifo_rd;
        data_valid <= 1'b1;
      end
    end
  end

  // A clear takes priority over a coincident underrun increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      underrun_cnt <= '0;
    end else if (clr_stats) begin
      underrun_cnt <= '0;
    end else if (underrun_evt && underrun_cnt != '1) begin
      underrun_cnt <= underrun_cnt + CNT_WIDTH'(1);
    end
  end

  assign fifo_level = level;
  assign state_o    = state;

endmodule
